// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sram_pkg
// Brief   : Shared types and the lane-merge helper for the 1R1W SRAM model.
// Revision: 1.0
// ============================================================================
package sram_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } sram_state_e;

  localparam int unsigned READ_LAT_MIN = 1;
  localparam int unsigned READ_LAT_MAX = 2;

  // Widest entry the merge helper handles; callers zero-extend into it.
  localparam int unsigned MERGE_W  = 1024;
  localparam int unsigned MERGE_AW = $clog2(MERGE_W);

  function automatic logic [MERGE_W-1:0] lane_merge(
    input logic [MERGE_W-1:0] old_d,
    input logic [MERGE_W-1:0] new_d,
    input logic [MERGE_W-1:0] mask,
    input int unsigned        gran
  );
    logic [MERGE_W-1:0] res;
    res = old_d;
    for (int unsigned i = 0; i < MERGE_W; i++) begin
      if (mask[MERGE_AW'(i / gran)]) begin
        res[MERGE_AW'(i)] = new_d[MERGE_AW'(i)];
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_clear_seq.sv
`default_nettype none
// ============================================================================
// Module  : sram_clear_seq
// Brief   : Post-reset sequencer that zeroes every entry, then flags init_done.
// Revision: 1.0
// ============================================================================
module sram_clear_seq
  import sram_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              RW0_clk,
  input  logic              reset,
  output logic              init_done,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

  sram_state_e       r_state;
  sram_state_e       w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;

  always_ff @(posedge RW0_clk or posedge reset) begin
    if (reset) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    clr_en      = 1'b0;
    case (r_state)
      INIT: begin
        clr_en = 1'b1;
        if (r_cnt == c_last) begin
          w_state_nxt = READY;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      READY:   ;
      default: w_state_nxt = INIT;
    endcase
  end

  assign clr_addr  = r_cnt;
  assign init_done = (r_state == READY);

endmodule
`default_nettype wire

// File: rtl/sram_array_1r1w_ext.sv
`default_nettype none
// ============================================================================
// Module  : sram_array_1r1w_ext
// Brief   : Behavioural 1R1W SRAM with lane write mask, post-reset clear,
//           1/2-cycle read latency and selectable read-during-write bypass.
// Revision: 1.0
// ============================================================================
module sram_array_1r1w_ext
  import sram_pkg::*;
#(
  parameter int  DATA_WIDTH = 80,
  parameter int  DEPTH      = 4096,
  parameter int  MASK_GRAN  = 8,
  parameter int  READ_LAT   = 1,
  parameter int  BYPASS     = 1,
  parameter int  ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int MASK_W     = DATA_WIDTH / MASK_GRAN
) (
  input  logic                  RW0_clk,
  input  logic                  reset,
  input  logic                  R0_en,
  input  logic [ADDR_W-1:0]     R0_addr,
  output logic [DATA_WIDTH-1:0] R0_data,
  output logic                  R0_valid,
  input  logic                  W0_en,
  input  logic [ADDR_W-1:0]     W0_addr,
  input  logic [MASK_W-1:0]     W0_mask,
  input  logic [DATA_WIDTH-1:0] W0_data,
  output logic                  init_done
);

  if (DATA_WIDTH % MASK_GRAN != 0) begin : g_err_gran
    $error("sram_array_1r1w_ext: DATA_WIDTH must be a multiple of MASK_GRAN");
  end
  if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_err_lat
    $error("sram_array_1r1w_ext: READ_LAT must be 1 or 2");
  end
  if (DATA_WIDTH > MERGE_W) begin : g_err_width
    $error("sram_array_1r1w_ext: DATA_WIDTH exceeds lane_merge capacity");
  end

  localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_clr_en;
  logic [ADDR_W-1:0]     w_clr_addr;
  logic                  w_rd_inrange;
  logic                  w_wr_inrange;
  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic                  w_rd_hit;
  logic [DATA_WIDTH-1:0] w_wr_old;
  logic [DATA_WIDTH-1:0] w_rd_old;
  logic [DATA_WIDTH-1:0] w_wr_merged;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] r_rd_q;
  logic                  r_v_q;

  sram_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .RW0_clk   (RW0_clk),
    .reset     (reset),
    .init_done (init_done),
    .clr_en    (w_clr_en),
    .clr_addr  (w_clr_addr)
  );

  // Addresses only go out of range when DEPTH is not a power of two.
  assign w_rd_inrange = ({1'b0, R0_addr} < c_depth);
  assign w_wr_inrange = ({1'b0, W0_addr} < c_depth);

  assign w_wr_fire = init_done & W0_en & w_wr_inrange & (|W0_mask);
  assign w_rd_fire = init_done & R0_en;

  assign w_wr_old    = r_mem[W0_addr];
  assign w_rd_old    = r_mem[R0_addr];
  assign w_wr_merged = DATA_WIDTH'(lane_merge(MERGE_W'(w_wr_old), MERGE_W'(W0_data),
                                              MERGE_W'(W0_mask), MASK_GRAN));

  assign w_rd_hit  = (BYPASS != 0) && w_wr_fire && (W0_addr == R0_addr);
  assign w_rd_word = !w_rd_inrange ? '0 : (w_rd_hit ? w_wr_merged : w_rd_old);

  // The clear sequencer owns the write port until init_done rises.
  always_ff @(posedge RW0_clk) begin
    if (w_clr_en) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_fire) begin
      r_mem[W0_addr] <= w_wr_merged;
    end
  end

  always_ff @(posedge RW0_clk or posedge reset) begin
    if (reset) begin
      r_rd_q <= '0;
      r_v_q  <= 1'b0;
    end else begin
      r_v_q <= w_rd_fire;
      if (w_rd_fire) begin
        r_rd_q <= w_rd_word;
      end
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] r_data2;
    logic                  r_valid2;

    always_ff @(posedge RW0_clk or posedge reset) begin
      if (reset) begin
        r_data2  <= '0;
        r_valid2 <= 1'b0;
      end else begin
        r_valid2 <= r_v_q;
        if (r_v_q) begin
          r_data2 <= r_rd_q;
        end
      end
    end

    assign R0_data  = r_data2;
    assign R0_valid = r_valid2;
  end else begin : g_lat1
    assign R0_data  = r_rd_q;
    assign R0_valid = r_v_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_array_1r1w_ext.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_array_1r1w_ext
// Brief   : Scoreboard bench driving two configurations (LAT1/bypass, LAT2/no bypass).
// Revision: 1.0
// ============================================================================
module tb_sram_array_1r1w_ext;

  localparam int DW    = 80;
  localparam int DEPTH = 3000;
  localparam int AW    = 12;
  localparam int MW    = 10;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          RW0_clk;
  logic          reset;
  logic          R0_en;
  logic [AW-1:0] R0_addr;
  logic          W0_en;
  logic [AW-1:0] W0_addr;
  logic [MW-1:0] W0_mask;
  logic [DW-1:0] W0_data;
  logic [DW-1:0] data_a, data_b;
  logic          valid_a, valid_b;
  logic          done_a, done_b;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc     = 0;
  int   n_total = 0;
  int   n_pass  = 0;

  localparam logic [DW-1:0] c_ones   = {DW{1'b1}};
  localparam logic [DW-1:0] c_low0   = 80'hFFFF_FFFF_FFFF_FFFF_FF00;
  localparam logic [DW-1:0] c_ones11 = 80'h1111_1111_1111_1111_1111;
  localparam logic [DW-1:0] c_twos22 = 80'h2222_2222_2222_2222_2222;
  localparam logic [DW-1:0] c_merged = 80'h1111_1111_1111_1111_2222;

  sram_array_1r1w_ext #(
    .DATA_WIDTH (DW), .DEPTH (DEPTH), .MASK_GRAN (8), .READ_LAT (1), .BYPASS (1)
  ) u_dut_a (
    .RW0_clk (RW0_clk), .reset (reset),
    .R0_en (R0_en), .R0_addr (R0_addr), .R0_data (data_a), .R0_valid (valid_a),
    .W0_en (W0_en), .W0_addr (W0_addr), .W0_mask (W0_mask), .W0_data (W0_data),
    .init_done (done_a)
  );

  sram_array_1r1w_ext #(
    .DATA_WIDTH (DW), .DEPTH (DEPTH), .MASK_GRAN (8), .READ_LAT (2), .BYPASS (0)
  ) u_dut_b (
    .RW0_clk (RW0_clk), .reset (reset),
    .R0_en (R0_en), .R0_addr (R0_addr), .R0_data (data_b), .R0_valid (valid_b),
    .W0_en (W0_en), .W0_addr (W0_addr), .W0_mask (W0_mask), .W0_data (W0_data),
    .init_done (done_b)
  );

  initial begin
    RW0_clk = 1'b0;
    forever #5 RW0_clk = ~RW0_clk;
  end

  always @(posedge RW0_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents valid read data.
  always @(negedge RW0_clk) begin : mon
    exp_t e;
    if (!reset) begin
      if (valid_a) begin
        if (qa.size() == 0) chk("a_unexpected_valid", 1, 0);
        else begin
          e = qa.pop_front();
          chk("a_data", data_a, e.data);
          chk("a_latency", cyc, e.due);
        end
      end
      if (valid_b) begin
        if (qb.size() == 0) chk("b_unexpected_valid", 1, 0);
        else begin
          e = qb.pop_front();
          chk("b_data", data_b, e.data);
          chk("b_latency", cyc, e.due);
        end
      end
    end
  end

  task automatic tick();
    @(posedge RW0_clk);
    @(negedge RW0_clk);
  endtask

  task automatic op(input bit ren, input logic [AW-1:0] ra, input logic [DW-1:0] ea,
                    input logic [DW-1:0] eb, input bit wen, input logic [AW-1:0] wa,
                    input logic [MW-1:0] wm, input logic [DW-1:0] wd);
    exp_t e;
    R0_en   = ren;
    R0_addr = ra;
    W0_en   = wen;
    W0_addr = wa;
    W0_mask = wm;
    W0_data = wd;
    if (ren) begin
      e.data = ea; e.due = cyc + 1; qa.push_back(e);
      e.data = eb; e.due = cyc + 2; qb.push_back(e);
    end
    tick();
    R0_en = 1'b0;
    W0_en = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] ex);
    op(1'b1, a, ex, ex, 1'b0, '0, '0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [MW-1:0] m, input logic [DW-1:0] d);
    op(1'b0, '0, '0, '0, 1'b1, a, m, d);
  endtask

  task automatic wait_init(input string name);
    int k;
    k = 0;
    while (done_a !== 1'b1 && k < DEPTH + 20) begin
      tick();
      k++;
    end
    chk(name, k, DEPTH);
    chk({name, "_b"}, done_b, 1'b1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((qa.size() + qb.size()) != 0 && k < 10) begin
      tick();
      k++;
    end
    chk("drain", qa.size() + qb.size(), 0);
  endtask

  initial begin
    int            addrs[6];
    logic [DW-1:0] ed;
    reset   = 1'b1;
    R0_en   = 1'b0;
    R0_addr = '0;
    W0_en   = 1'b0;
    W0_addr = '0;
    W0_mask = '0;
    W0_data = '0;
    #2;
    chk("rst_valid_a", valid_a, 0);
    chk("rst_valid_b", valid_b, 0);
    chk("rst_data_a", data_a, 0);
    chk("rst_data_b", data_b, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_done_b", done_b, 0);
    repeat (3) @(negedge RW0_clk);
    reset = 1'b0;

    // Requests issued during the clear must be ignored.
    R0_en = 1'b1; R0_addr = 12'd5;
    W0_en = 1'b1; W0_addr = 12'd5; W0_mask = '1; W0_data = c_ones;
    wait_init("init_latency");
    R0_en = 1'b0; W0_en = 1'b0;

    addrs = '{0, 1, 5, 7, 1500, 2999};
    for (int i = 0; i < 6; i++) rd(AW'(addrs[i]), '0);

    wr(12'd5, 10'h3FF, c_ones);
    wr(12'd5, 10'h001, '0);
    rd(12'd5, c_low0);

    wr(12'd7, 10'h3FF, c_ones11);
    op(1'b1, 12'd7, c_merged, c_ones11, 1'b1, 12'd7, 10'h003, c_twos22);
    rd(12'd7, c_merged);

    for (int i = 0; i < 32; i++) begin
      ed = (i == 5) ? c_low0 : ((i == 7) ? c_merged : '0);
      op(1'b1, AW'(i), ed, ed, 1'b1, AW'(32 + i), 10'h3FF, {8'hC3, 72'(32 + i)});
    end
    for (int i = 32; i < 64; i++) rd(AW'(i), {8'hC3, 72'(i)});
    drain();

    wr(12'd10, 10'h3FF, c_ones);
    wr(12'd99, 10'h3FF, c_ones);
    wr(12'd150, 10'h3FF, c_ones);
    reset = 1'b1;
    @(negedge RW0_clk);
    reset = 1'b0;
    repeat (100) tick();
    chk("midinit_done_a", done_a, 0);
    reset = 1'b1;
    repeat (2) @(negedge RW0_clk);
    chk("midinit_rst_done_a", done_a, 0);
    chk("midinit_rst_done_b", done_b, 0);
    reset = 1'b0;
    wait_init("reinit_latency");
    rd(12'd0, '0);
    rd(12'd5, '0);
    rd(12'd10, '0);
    rd(12'd99, '0);
    rd(12'd150, '0);

    wr(12'd3500, 10'h3FF, 80'hDEAD);
    rd(12'd3500, '0);
    rd(12'd500, '0);
    rd(12'd1452, '0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
